avalon_pio_in: RTL



---
 rtl/avalon_pio_in.sv | 138 +++++++++++++
 1 files changed

// File: rtl/avalon_pio_in.sv
// avalon_pio_in: Avalon-MM input PIO. Synchronises an external bus,
// latches per-bit edges into sticky EDGECAP flags and raises a maskable
// level interrupt. Word map: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP.

// Per-bit synchroniser and edge detector, instantiated once per input bit.
module avalon_pio_in_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the raw input through the synchroniser; prev trails sync_out by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  // Edge flavour is fixed at elaboration: 0 rising, 1 falling, otherwise any.
  always_comb begin
    edge_det = 1'b0;
    case (EDGE_TYPE)
      0:       edge_det = sync & ~prev;
      1:       edge_det = ~sync & prev;
      default: edge_det = sync ^ prev;
    endcase
  end

endmodule

module avalon_pio_in #(
  parameter int WIDTH       = 18,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_ECAP = 2'd3;

  logic [WIDTH-1:0]   sync_out;
  logic [WIDTH-1:0]   edge_hit;
  logic [WIDTH-1:0]   irqmask;
  logic [WIDTH-1:0]   edgecap;
  logic [WIDTH-1:0]   cap_set;
  logic [WIDTH-1:0]   cap_clr;
  logic [SYNC_STAGES:0] arm_pipe;
  logic               armed;
  logic               wr;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      avalon_pio_in_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
      ) u_bit (
        .clk      (clk),
        .reset    (reset),
        .din      (in_port[i]),
        .sync     (sync_out[i]),
        .edge_det (edge_hit[i])
      );
    end
  endgenerate

  // Arm shift register fills with ones after reset; edges only count once
  // the synchroniser and prev have flushed the pre-reset input levels.
  always_ff @(posedge clk) begin
    if (reset) arm_pipe <= '0;
    else       arm_pipe <= {arm_pipe[SYNC_STAGES-1:0], 1'b1};
  end

  assign armed   = arm_pipe[SYNC_STAGES];
  assign cap_set = edge_hit & {WIDTH{armed}};
  assign cap_clr = (wr && address == A_ECAP) ? writedata[WIDTH-1:0] : '0;

  // IRQMASK write port; bits above WIDTH are dropped.
  always_ff @(posedge clk) begin
    if (reset)                        irqmask <= '0;
    else if (wr && address == A_MASK) irqmask <= writedata[WIDTH-1:0];
  end

  // Sticky edge flags: write-1-clear, but a same-cycle new edge keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) edgecap <= '0;
    else       edgecap <= (edgecap & ~cap_clr) | cap_set;
  end

  // Read mux from pre-update register contents, zero-extended to 32 bits.
  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:  rd_mux[WIDTH-1:0] = sync_out;
      A_MASK:  rd_mux[WIDTH-1:0] = irqmask;
      A_ECAP:  rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data gives a fixed one-clk read latency.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign irq = |(edgecap & irqmask);

endmodule
